// File: rtl/max_argmax_tree_pipe.sv
// max_argmax_tree_pipe: registered max/argmax reduction tree over float lanes.
// Define MAX_TREE_NAN_CHECK_EN for NaN-lowest ordering and the o_all_nan flag.
module max_argmax_tree_pipe #(
    parameter int DATA_WIDTH = 32,
    parameter int EXP_WIDTH  = 8,
    parameter int CHANNELS   = 4,
    localparam int IDX_WIDTH = (CHANNELS > 2) ? $clog2(CHANNELS) : 1,
    localparam int LEVELS    = $clog2(CHANNELS)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           i_valid,
    output logic                           o_ready,
    input  logic [DATA_WIDTH*CHANNELS-1:0] i_data,
    input  logic                           i_ready,
    output logic                           o_valid,
    output logic [DATA_WIDTH-1:0]          o_data,
    output logic [IDX_WIDTH-1:0]           o_index
`ifdef MAX_TREE_NAN_CHECK_EN
    ,
    output logic                           o_all_nan
`endif
);

    localparam int MANT_WIDTH = DATA_WIDTH - 1 - EXP_WIDTH;

    // Entries at tree level l (level 0 is the raw input vector).
    function automatic int lvl_n(input int l);
        int n;
        n = CHANNELS;
        for (int t = 0; t < l; t++) begin
            n = (n + 1) / 2;
        end
        return n;
    endfunction

    // First register slot of pipeline stage s in the flat storage.
    function automatic int lvl_off(input int s);
        int o;
        o = 0;
        for (int t = 0; t < s; t++) begin
            o = o + lvl_n(t + 1);
        end
        return o;
    endfunction

    localparam int TOTAL = lvl_off(LEVELS);
    localparam int HALF  = (CHANNELS + 1) / 2;

    // Magnitude x > y, exponent field first, then mantissa.
    function automatic logic mag_gt(
        input logic [DATA_WIDTH-2:0] x,
        input logic [DATA_WIDTH-2:0] y
    );
        logic [EXP_WIDTH-1:0] ex;
        logic [EXP_WIDTH-1:0] ey;
        ex = x[DATA_WIDTH-2 -: EXP_WIDTH];
        ey = y[DATA_WIDTH-2 -: EXP_WIDTH];
        if (ex != ey) begin
            return ex > ey;
        end
        return x[MANT_WIDTH-1:0] > y[MANT_WIDTH-1:0];
    endfunction

`ifdef MAX_TREE_NAN_CHECK_EN
    function automatic logic is_nan(input logic [DATA_WIDTH-1:0] v);
        return (&v[DATA_WIDTH-2 -: EXP_WIDTH]) && (|v[MANT_WIDTH-1:0]);
    endfunction
`endif

    // True only when b is strictly greater than a, so ties keep a.
    function automatic logic b_wins(
        input logic [DATA_WIDTH-1:0] a,
        input logic [DATA_WIDTH-1:0] b
    );
        logic sa;
        logic sb;
        logic [DATA_WIDTH-2:0] ma;
        logic [DATA_WIDTH-2:0] mb;
        sa = a[DATA_WIDTH-1];
        sb = b[DATA_WIDTH-1];
        ma = a[DATA_WIDTH-2:0];
        mb = b[DATA_WIDTH-2:0];
`ifdef MAX_TREE_NAN_CHECK_EN
        if (is_nan(b)) begin
            return 1'b0;
        end
        if (is_nan(a)) begin
            return 1'b1;
        end
`endif
        if ((ma == '0) && (mb == '0)) begin
            return 1'b0;
        end
        if (sa != sb) begin
            return sa;
        end
        if (!sa) begin
            return mag_gt(mb, ma);
        end
        return mag_gt(ma, mb);
    endfunction

    logic [DATA_WIDTH-1:0] r_val   [TOTAL];
    logic [IDX_WIDTH-1:0]  r_idx   [TOTAL];
    logic [DATA_WIDTH-1:0] nxt_val [TOTAL];
    logic [IDX_WIDTH-1:0]  nxt_idx [TOTAL];
    logic [LEVELS-1:0]     r_vld;
    logic                  adv;

    logic [DATA_WIDTH-1:0] va;
    logic [DATA_WIDTH-1:0] vb;
    logic [IDX_WIDTH-1:0]  xa;
    logic [IDX_WIDTH-1:0]  xb;
    logic                  has_b;
    int                    ia;
    int                    ib;

`ifdef MAX_TREE_NAN_CHECK_EN
    logic [TOTAL-1:0] r_nan;
    logic [TOTAL-1:0] nxt_nan;
    logic             na;
    logic             nb;
`endif

    assign adv     = ~o_valid | i_ready;
    assign o_ready = adv;
    assign o_valid = r_vld[LEVELS-1];
    assign o_data  = r_val[TOTAL-1];
    assign o_index = r_idx[TOTAL-1];
`ifdef MAX_TREE_NAN_CHECK_EN
    assign o_all_nan = r_nan[TOTAL-1];
`endif

    // Pairwise reduction of every level into the next stage's registers.
    always_comb begin
        for (int k = 0; k < TOTAL; k++) begin
            nxt_val[k] = '0;
            nxt_idx[k] = '0;
        end
        va    = '0;
        vb    = '0;
        xa    = '0;
        xb    = '0;
        has_b = 1'b0;
        ia    = 0;
        ib    = 0;
`ifdef MAX_TREE_NAN_CHECK_EN
        nxt_nan = '0;
        na      = 1'b0;
        nb      = 1'b0;
`endif
        for (int s = 0; s < LEVELS; s++) begin
            for (int j = 0; j < HALF; j++) begin
                if (j < lvl_n(s + 1)) begin
                    ia    = 2 * j;
                    ib    = 2 * j + 1;
                    has_b = ib < lvl_n(s);
                    vb    = '0;
                    xb    = '0;
                    if (s == 0) begin
                        va = i_data[DATA_WIDTH*ia +: DATA_WIDTH];
                        xa = IDX_WIDTH'(ia);
                        if (has_b) begin
                            vb = i_data[DATA_WIDTH*ib +: DATA_WIDTH];
                            xb = IDX_WIDTH'(ib);
                        end
                    end else begin
                        va = r_val[lvl_off(s - 1) + ia];
                        xa = r_idx[lvl_off(s - 1) + ia];
                        if (has_b) begin
                            vb = r_val[lvl_off(s - 1) + ib];
                            xb = r_idx[lvl_off(s - 1) + ib];
                        end
                    end
`ifdef MAX_TREE_NAN_CHECK_EN
                    if (s == 0) begin
                        na = is_nan(va);
                        nb = has_b ? is_nan(vb) : 1'b1;
                    end else begin
                        na = r_nan[lvl_off(s - 1) + ia];
                        nb = has_b ? r_nan[lvl_off(s - 1) + ib] : 1'b1;
                    end
                    nxt_nan[lvl_off(s) + j] = na & nb;
`endif
                    if (has_b && b_wins(va, vb)) begin
                        nxt_val[lvl_off(s) + j] = vb;
                        nxt_idx[lvl_off(s) + j] = xb;
                    end else begin
                        nxt_val[lvl_off(s) + j] = va;
                        nxt_idx[lvl_off(s) + j] = xa;
                    end
                end
            end
        end
    end

    // All stages shift together on advance and hold together on stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld <= '0;
            for (int k = 0; k < TOTAL; k++) begin
                r_val[k] <= '0;
                r_idx[k] <= '0;
            end
`ifdef MAX_TREE_NAN_CHECK_EN
            r_nan <= '0;
`endif
        end else if (adv) begin
            r_vld <= (r_vld << 1) | LEVELS'(i_valid);
            for (int k = 0; k < TOTAL; k++) begin
                r_val[k] <= nxt_val[k];
                r_idx[k] <= nxt_idx[k];
            end
`ifdef MAX_TREE_NAN_CHECK_EN
            r_nan <= nxt_nan;
`endif
        end
    end

endmodule

// File: tb/tb_max_argmax_tree_pipe.sv
// tb_max_argmax_tree_pipe: CHANNELS 2/4/5 instances against a flat argmax model.
// Covers directed vectors, backpressure streaming, reset flush and random traffic.
`timescale 1ns/1ps
module tb_max_argmax_tree_pipe;

    typedef struct {
        logic [31:0] d;
        logic [5:0]  i;
        logic        n;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        i_valid;
    logic        rdy_main;
    logic        rdy_aux;
    logic [31:0] ch [5];

    logic [63:0]  d2;
    logic [127:0] d4;
    logic [159:0] d5;
    assign d2 = {ch[1], ch[0]};
    assign d4 = {ch[3], ch[2], ch[1], ch[0]};
    assign d5 = {ch[4], ch[3], ch[2], ch[1], ch[0]};

    logic        r2, r4, r5;
    logic        v2, v4, v5;
    logic [31:0] q2, q4, q5;
    logic [0:0]  x2;
    logic [1:0]  x4;
    logic [2:0]  x5;
`ifdef MAX_TREE_NAN_CHECK_EN
    logic        n2, n4, n5;
`endif

    max_argmax_tree_pipe #(.CHANNELS(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .o_ready(r2),
        .i_data(d2), .i_ready(rdy_aux), .o_valid(v2), .o_data(q2),
        .o_index(x2)
`ifdef MAX_TREE_NAN_CHECK_EN
        , .o_all_nan(n2)
`endif
    );

    max_argmax_tree_pipe #(.CHANNELS(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .o_ready(r4),
        .i_data(d4), .i_ready(rdy_main), .o_valid(v4), .o_data(q4),
        .o_index(x4)
`ifdef MAX_TREE_NAN_CHECK_EN
        , .o_all_nan(n4)
`endif
    );

    max_argmax_tree_pipe #(.CHANNELS(5)) u_dut5 (
        .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .o_ready(r5),
        .i_data(d5), .i_ready(rdy_aux), .o_valid(v5), .o_data(q5),
        .o_index(x5)
`ifdef MAX_TREE_NAN_CHECK_EN
        , .o_all_nan(n5)
`endif
    );

    int          checks = 0;
    int          errors = 0;
    int          nch [3] = '{2, 4, 5};
    int          lat [3] = '{1, 2, 3};
    logic        ov [3];
    logic        ordy [3];
    logic        on [3];
    logic        rdy [3];
    logic [31:0] od [3];
    logic [5:0]  oi [3];
    logic        hold [3];
    logic [31:0] hd [3];
    logic [5:0]  hi [3];
    logic        acc4;
    exp_t        sb0 [$];
    exp_t        sb1 [$];
    exp_t        sb2 [$];

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic nan_v(input logic [31:0] v);
        return (v[30:23] == 8'hFF) && (v[22:0] != 0);
    endfunction

    // Total order key: sign/magnitude to signed integer, +0 == -0.
    function automatic longint key(input logic [31:0] v);
`ifdef MAX_TREE_NAN_CHECK_EN
        if (nan_v(v)) return -(64'sd1 <<< 40);
`endif
        if (v[30:0] == 0) return 0;
        if (v[31]) return -longint'({33'd0, v[30:0]});
        return longint'({33'd0, v[30:0]});
    endfunction

    // Reference: first channel holding the largest key.
    function automatic exp_t model(input int n);
        exp_t e;
        int   best;
        logic alln;
        best = 0;
        alln = 1'b1;
        for (int i = 0; i < n; i++) begin
            if (key(ch[i]) > key(ch[best])) best = i;
            if (!nan_v(ch[i])) alln = 1'b0;
        end
        e.d = ch[best];
        e.i = 6'(best);
`ifdef MAX_TREE_NAN_CHECK_EN
        e.n = alln;
`else
        e.n = 1'b0;
`endif
        return e;
    endfunction

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 9))
            0: return 32'h0000_0000;
            1: return 32'h8000_0000;
            2: return 32'h3F80_0000;
            3: return 32'hBF80_0000;
            4: return 32'h4000_0000;
            5: return 32'hC000_0000;
            6: return 32'h7F80_0000;
            7: return 32'hFF80_0000;
            8: return 32'h7FC0_0000;
            default: return $urandom;
        endcase
    endfunction

    task automatic sb_push(input int k, input exp_t e);
        case (k)
            0: sb0.push_back(e);
            1: sb1.push_back(e);
            default: sb2.push_back(e);
        endcase
    endtask

    function automatic int sb_size(input int k);
        case (k)
            0: return sb0.size();
            1: return sb1.size();
            default: return sb2.size();
        endcase
    endfunction

    task automatic sb_pop(input int k, output exp_t e);
        case (k)
            0: e = sb0.pop_front();
            1: e = sb1.pop_front();
            default: e = sb2.pop_front();
        endcase
    endtask

    task automatic snap();
        ov[0] = v2; ov[1] = v4; ov[2] = v5;
        ordy[0] = r2; ordy[1] = r4; ordy[2] = r5;
        od[0] = q2; od[1] = q4; od[2] = q5;
        oi[0] = 6'(x2); oi[1] = 6'(x4); oi[2] = 6'(x5);
        rdy[0] = rdy_aux; rdy[1] = rdy_main; rdy[2] = rdy_aux;
`ifdef MAX_TREE_NAN_CHECK_EN
        on[0] = n2; on[1] = n4; on[2] = n5;
`else
        on[0] = 1'b0; on[1] = 1'b0; on[2] = 1'b0;
`endif
    endtask

    task automatic clear_sb();
        sb0.delete();
        sb1.delete();
        sb2.delete();
        for (int k = 0; k < 3; k++) hold[k] = 1'b0;
    endtask

    // Pre-edge monitor: handshake bookkeeping and output checks.
    task automatic mon();
        exp_t e;
        snap();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("ready%0d", nch[k]), ordy[k], !ov[k] || rdy[k]);
            if (hold[k]) begin
                chk($sformatf("hold_v%0d", nch[k]), ov[k], 1);
                chk($sformatf("hold_d%0d", nch[k]), od[k], hd[k]);
                chk($sformatf("hold_i%0d", nch[k]), oi[k], hi[k]);
            end
            if (ov[k] && rdy[k]) begin
                checks++;
                assert (sb_size(k) > 0) else begin
                    errors++;
                    $error("FAIL extra%0d got=%0h exp=none", nch[k], od[k]);
                end
                if (sb_size(k) > 0) begin
                    sb_pop(k, e);
                    chk($sformatf("data%0d", nch[k]), od[k], e.d);
                    chk($sformatf("idx%0d", nch[k]), oi[k], e.i);
                    chk($sformatf("nan%0d", nch[k]), on[k], e.n);
                end
            end
            hold[k] = ov[k] && !rdy[k];
            hd[k] = od[k];
            hi[k] = oi[k];
            if (i_valid && ordy[k]) sb_push(k, model(nch[k]));
        end
        acc4 = i_valid && ordy[1];
    endtask

    task automatic cycle();
        @(negedge clk);
        mon();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        i_valid = 1'b0;
        rdy_main = 1'b1;
        rdy_aux = 1'b1;
        repeat (6) cycle();
    endtask

    // One isolated vector with exact-latency checks on DUT k.
    task automatic dir(input string tag, input int k,
                       input logic [31:0] a4, input logic [31:0] a3,
                       input logic [31:0] a2, input logic [31:0] a1,
                       input logic [31:0] a0, input logic [31:0] ed,
                       input logic [5:0] ei, input logic en);
        drain();
        ch[4] = a4; ch[3] = a3; ch[2] = a2; ch[1] = a1; ch[0] = a0;
        i_valid = 1'b1;
        for (int t = 1; t <= lat[k]; t++) begin
            cycle();
            i_valid = 1'b0;
            snap();
            if (t < lat[k]) begin
                chk({tag, "_early"}, ov[k], 0);
            end else begin
                chk({tag, "_v"}, ov[k], 1);
                chk({tag, "_d"}, od[k], ed);
                chk({tag, "_i"}, oi[k], ei);
                chk({tag, "_n"}, on[k], en);
            end
        end
        cycle();
    endtask

    int pat [6] = '{1, 0, 0, 1, 1, 0};

    initial begin
        int v;
        int c;
        rst_n = 1'b0;
        i_valid = 1'b0;
        rdy_main = 1'b0;
        rdy_aux = 1'b0;
        for (int j = 0; j < 5; j++) ch[j] = 32'h0;
        for (int k = 0; k < 3; k++) hold[k] = 1'b0;
        acc4 = 1'b0;
        #2;
        snap();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst_v%0d", nch[k]), ov[k], 0);
            chk($sformatf("rst_d%0d", nch[k]), od[k], 0);
            chk($sformatf("rst_i%0d", nch[k]), oi[k], 0);
            chk($sformatf("rst_n%0d", nch[k]), on[k], 0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        dir("mix4", 1, 32'h0, 32'h4000_0000, 32'hBF80_0000,
            32'h3F00_0000, 32'h3F80_0000, 32'h4000_0000, 6'd3, 1'b0);
        dir("neg4", 1, 32'h0, 32'hC000_0000, 32'hBF00_0000,
            32'hBF80_0000, 32'hC000_0000, 32'hBF00_0000, 6'd2, 1'b0);
        dir("tie4", 1, 32'h0, 32'h3F80_0000, 32'h3F80_0000,
            32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 6'd0, 1'b0);
        dir("zero2", 0, 32'h0, 32'h0, 32'h0,
            32'h0000_0000, 32'h8000_0000, 32'h8000_0000, 6'd0, 1'b0);
        dir("zero4", 1, 32'h0, 32'hBF80_0000, 32'hBF80_0000,
            32'h0000_0000, 32'h8000_0000, 32'h8000_0000, 6'd0, 1'b0);
        dir("odd5", 2, 32'h3F80_0000, 32'hBF80_0000, 32'hBF80_0000,
            32'hBF80_0000, 32'hBF80_0000, 32'h3F80_0000, 6'd4, 1'b0);
`ifdef MAX_TREE_NAN_CHECK_EN
        dir("nan4", 1, 32'h0, 32'h7FC0_0000, 32'hFF80_0000,
            32'h7FC0_0000, 32'h7FC0_0000, 32'hFF80_0000, 6'd2, 1'b0);
        dir("alln4", 1, 32'h0, 32'h7FC0_0000, 32'h7FC0_0000,
            32'h7FC0_0000, 32'h7FC0_0000, 32'h7FC0_0000, 6'd0, 1'b1);
`endif

        drain();
        v = 0;
        c = 0;
        for (int j = 0; j < 5; j++) ch[j] = rnd_val();
        while (v < 6 && c < 200) begin
            i_valid = 1'b1;
            rdy_main = pat[c % 6][0];
            rdy_aux = pat[(c + 3) % 6][0];
            cycle();
            if (acc4) begin
                v++;
                for (int j = 0; j < 5; j++) ch[j] = rnd_val();
            end
            c++;
        end
        chk("stream_fed", 64'(v), 64'd6);
        i_valid = 1'b0;
        repeat (24) begin
            rdy_main = pat[c % 6][0];
            rdy_aux = pat[(c + 3) % 6][0];
            cycle();
            c++;
        end
        drain();
        for (int k = 0; k < 3; k++)
            chk($sformatf("stream_left%0d", nch[k]), 64'(sb_size(k)), 0);

        drain();
        i_valid = 1'b1;
        for (int j = 0; j < 5; j++) ch[j] = rnd_val();
        cycle();
        for (int j = 0; j < 5; j++) ch[j] = rnd_val();
        cycle();
        i_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        snap();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("mid_rst_v%0d", nch[k]), ov[k], 0);
            chk($sformatf("mid_rst_d%0d", nch[k]), od[k], 0);
        end
        clear_sb();
        cycle();
        cycle();
        rst_n = 1'b1;
        for (int t = 0; t < 4; t++) begin
            cycle();
            snap();
            for (int k = 0; k < 3; k++)
                chk($sformatf("stale%0d", nch[k]), ov[k], 0);
        end
        dir("post_rst4", 1, 32'h0, 32'hBF80_0000, 32'h3F80_0000,
            32'h4000_0000, 32'hC000_0000, 32'h4000_0000, 6'd1, 1'b0);

        for (int t = 0; t < 500; t++) begin
            i_valid = ($urandom_range(0, 3) != 0);
            for (int j = 0; j < 5; j++) ch[j] = rnd_val();
            rdy_main = ($urandom_range(0, 2) != 0);
            rdy_aux = $urandom_range(0, 1);
            cycle();
        end
        drain();
        for (int k = 0; k < 3; k++)
            chk($sformatf("rand_left%0d", nch[k]), 64'(sb_size(k)), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/max_argmax_tree_pipe.md
Name: max_argmax_tree_pipe

Overview:
- Pipelined, parametrised max-reduction tree over CHANNELS IEEE-754 values.
- Returns both the maximum value and the channel index of that maximum (argmax), e.g. the greedy action and its max-Q value for the Q-learning update path.
- Each tree level is registered. A valid/ready handshake with global stall lets a new vector enter every cycle.
- Successor to the combinational single-level max layer: full tree, argmax, pipelining and backpressure.

Parameters:
- DATA_WIDTH, 32, float word width; layout is sign | EXP_WIDTH exponent | mantissa.
- EXP_WIDTH, 8, exponent field width; used only by the optional NaN check.
- CHANNELS, 4, number of input values; legal range 2..64.
- IDX_WIDTH, max(1, clog2(CHANNELS)), width of the argmax index (derived localparam).
- LEVELS, clog2(CHANNELS), pipeline depth (derived localparam).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- i_valid  input  1  i_data holds a valid vector
- o_ready  output  1  block accepts a vector this cycle
- i_data  input  DATA_WIDTH*CHANNELS  channel k occupies bits [DATA_WIDTH*(k+1)-1 : DATA_WIDTH*k]
- i_ready  input  1  downstream accepts the result
- o_valid  output  1  o_data/o_index are valid
- o_data  output  DATA_WIDTH  maximum value
- o_index  output  IDX_WIDTH  lowest channel index holding the maximum

Behaviour:
- Reset (async assert, release on a clk edge): all stage valid bits = 0, all data/index registers = 0; o_valid=0, o_data=0, o_index=0.
- Pipeline advance: adv = ~o_valid | i_ready; o_ready = adv. The signal is combinational, with no dependency on i_valid.
- When adv=1, every stage shifts by one. Stage 0 captures i_valid and the level-0 results.
- When adv=0, all stages hold. i_data is ignored, and o_data/o_index/o_valid stay stable.
- Latency: exactly LEVELS cycles from an accepted input to o_valid when there is no stall. Throughput is 1 vector/cycle.
- Level structure:
  - Level L has N_L entries: N_0 = CHANNELS, N_{L+1} = ceil(N_L/2).
  - Pairs (2j, 2j+1) are reduced into entry j.
  - When N_L is odd, the last entry passes through unchanged (value and index) into a register.
  - Each entry carries value plus original channel index.
- Comparison (a = lower-index entry, b = higher-index entry; pick b only if b > a strictly):
  - Signs differ and not both zero: the positive one is greater.
  - Both positive: the larger magnitude bits win.
  - Both negative: the smaller magnitude bits win.
  - +0 and -0 compare equal.
  - Equal values: pick a, so the lowest index wins ties at every level.
- Bubbles (i_valid=0 when adv=1) propagate as invalid stages. Data registers may update freely when their stage valid=0.
- Reset mid-operation: all in-flight results are discarded immediately, and o_valid drops to 0 asynchronously.
- CHANNELS=2: LEVELS=1, single comparator, IDX_WIDTH=1.

Optional Feature:
- Macro MAX_TREE_NAN_CHECK_EN.
- When defined:
  - A value with exponent all-ones and mantissa nonzero is NaN. NaN compares below every non-NaN value, including -inf.
  - Two NaNs compare equal, so lowest index wins.
  - Extra output o_all_nan (1 bit, reset 0) is asserted with o_valid when every channel of that vector is NaN. o_data is then the lowest-index NaN and o_index that index.
  - o_all_nan holds under stall like the other outputs.
- When undefined: no NaN detection; NaNs are compared by raw sign/magnitude rules. Port o_all_nan does not exist.

Test Plan:
- CHANNELS=4, i_data={2.0(40000000), -1.0(BF800000), 0.5(3F000000), 1.0(3F800000)} (ch3..ch0), i_i_ready=1 -> after 2 cycles o_valid=1, o_data=40000000, o_index=3.
- Negatives {-2.0(C0000000), -0.5(BF000000), -1.0, -2.0} (ch3..ch0) -> o_data=BF000000, o_index=2. Tie {1.0,1.0,1.0,1.0} -> o_index=0. {+0 ch1, -0 ch0} with CHANNELS=2 -> o_index=0.
- CHANNELS=5, max at ch4 (odd passthrough)=3F800000, others BF800000 -> latency 3, o_data=3F800000, o_index=4.
- Stream 6 back-to-back vectors with i_ready toggled 1,0,0,1,1,0...:
  - No result lost or duplicated, results in order.
  - o_data/o_index stable while o_valid=1 & i_ready=0.
  - o_ready=0 exactly during stall cycles with o_valid=1.
- Assert rst_n=0 mid-stream with 2 vectors in flight -> o_valid=0 immediately, no stale outputs after release; next vector appears after LEVELS cycles.
- With MAX_TREE_NAN_CHECK_EN:
  - {7FC00000, FF800000(-inf), 7FC00000, 7FC00000} -> o_data=FF800000, o_index=2, o_all_nan=0.
  - All four 7FC00000 -> o_index=0, o_all_nan=1.
